// File: rtl/lc3b_control.sv
// lc3b_control: multicycle control FSM for the LC-3b datapath.
// Sequences fetch, decode and execute. It drives the register load enables, the mux selects,
// the ALU op and the memory request handshakes. It also counts retired instructions.
//
// Ports:
//   clk, rst_n        clock and synchronous active-low reset
//   opcode, bit5      IR[15:12] and IR[5] from the datapath
//   branch_enable     BR condition (IR nzp AND CC), consulted only in the BR state
//   mem_resp          memory completion, may arrive in the same cycle as the request
//   load_*            register load enables (PC, IR, regfile, MAR, MDR, CC)
//   *mux_sel, aluop   datapath steering
//   mem_read/write    memory requests, held until mem_resp
//   instr_done        one-cycle pulse in the last cycle of each instruction
//   instret           count of instr_done pulses, wraps modulo 2^CNT_W
module lc3b_control #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [3:0]       opcode,
   input  logic             bit5,
   input  logic             branch_enable,
   input  logic             mem_resp,
   output logic             load_pc,
   output logic             load_ir,
   output logic             load_regfile,
   output logic             load_mar,
   output logic             load_mdr,
   output logic             load_cc,
   output logic [1:0]       pcmux_sel,
   output logic [1:0]       alumux_sel,
   output logic [1:0]       aluop,
   output logic [1:0]       regfilemux_sel,
   output logic             marmux_sel,
   output logic             mdrmux_sel,
   output logic             storemux_sel,
   output logic             mem_read,
   output logic             mem_write,
   output logic             instr_done,
   output logic [CNT_W-1:0] instret
);

   typedef enum logic [4:0] {
      StFetch1, StFetch2, StFetch3, StDecode,
      StAdd, StAnd, StNot, StBr, StBrTaken,
      StLdr1, StLdr2, StLdr3, StStr1, StStr2, StStr3,
      StJmp, StLea, StIllegal
   } state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] instret_q, instret_d;

   // Next state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StFetch1: state_d = StFetch2;
         StFetch2: if (mem_resp) state_d = StFetch3;
         StFetch3: state_d = StDecode;
         StDecode: begin
            unique case (opcode)
               4'b0001: state_d = StAdd;
               4'b0101: state_d = StAnd;
               4'b1001: state_d = StNot;
               4'b0000: state_d = StBr;
               4'b0110: state_d = StLdr1;
               4'b0111: state_d = StStr1;
               4'b1100: state_d = StJmp;
               4'b1110: state_d = StLea;
               default: state_d = StIllegal;
            endcase
         end
         StBr:     state_d = branch_enable ? StBrTaken : StFetch1;
         StLdr1:   state_d = StLdr2;
         StLdr2:   if (mem_resp) state_d = StLdr3;
         StStr1:   state_d = StStr2;
         StStr2:   state_d = StStr3;
         StStr3:   if (mem_resp) state_d = StFetch1;
         default:  state_d = StFetch1;
      endcase
   end

   // Moore output decode; only the memory states look at mem_resp
   always_comb begin
      load_pc        = 1'b0;
      load_ir        = 1'b0;
      load_regfile   = 1'b0;
      load_mar       = 1'b0;
      load_mdr       = 1'b0;
      load_cc        = 1'b0;
      pcmux_sel      = 2'd0;
      alumux_sel     = 2'd0;
      aluop          = 2'd0;
      regfilemux_sel = 2'd0;
      marmux_sel     = 1'b0;
      mdrmux_sel     = 1'b0;
      storemux_sel   = 1'b0;
      mem_read       = 1'b0;
      mem_write      = 1'b0;
      instr_done     = 1'b0;
      unique case (state_q)
         StFetch1: begin
            marmux_sel = 1'b1;
            load_mar   = 1'b1;
            load_pc    = 1'b1;
         end
         StFetch2, StLdr2: begin
            mem_read   = 1'b1;
            mdrmux_sel = 1'b1;
            load_mdr   = mem_resp;
         end
         StFetch3: load_ir = 1'b1;
         StAdd, StAnd: begin
            aluop        = (state_q == StAnd) ? 2'd1 : 2'd0;
            alumux_sel   = {1'b0, bit5};
            load_regfile = 1'b1;
            load_cc      = 1'b1;
            instr_done   = 1'b1;
         end
         StNot: begin
            aluop        = 2'd2;
            load_regfile = 1'b1;
            load_cc      = 1'b1;
            instr_done   = 1'b1;
         end
         StBr: instr_done = ~branch_enable;
         StBrTaken: begin
            pcmux_sel  = 2'd1;
            load_pc    = 1'b1;
            instr_done = 1'b1;
         end
         StLdr1, StStr1: begin
            // Base + offset6 address through the ALU into MAR
            alumux_sel = 2'd2;
            load_mar   = 1'b1;
         end
         StLdr3: begin
            regfilemux_sel = 2'd1;
            load_regfile   = 1'b1;
            load_cc        = 1'b1;
            instr_done     = 1'b1;
         end
         StStr2: begin
            // Source register appears on the SR2 port and passes through the ALU as B
            storemux_sel = 1'b1;
            aluop        = 2'd3;
            load_mdr     = 1'b1;
         end
         StStr3: begin
            mem_write  = 1'b1;
            instr_done = mem_resp;
         end
         StJmp: begin
            pcmux_sel  = 2'd2;
            load_pc    = 1'b1;
            instr_done = 1'b1;
         end
         StLea: begin
            regfilemux_sel = 2'd2;
            load_regfile   = 1'b1;
            load_cc        = 1'b1;
            instr_done     = 1'b1;
         end
         StIllegal: instr_done = 1'b1;
         default: ;
      endcase
   end

   assign instret_d = instret_q + {{(CNT_W-1){1'b0}}, instr_done};
   assign instret   = instret_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= StFetch1;
         instret_q <= '0;
      end else begin
         state_q   <= state_d;
         instret_q <= instret_d;
      end
   end

endmodule

// File: doc/lc3b_control.md
Name: lc3b_control

Overview:
- Multicycle control FSM for the LC-3b datapath.
- Sequences fetch, decode and execute by driving load enables, mux selects, ALU op and memory handshakes around the instruction register, PC, MAR/MDR, register file and CC.
- Consumes the decoded opcode, bit5 and branch_enable from the datapath.
- Keeps a retired-instruction counter for performance and verification.

Parameters:
- CNT_W, 16, width of the retired-instruction counter instret (wraps modulo 2^CNT_W).

Ports:
- clk  in  1  system clock, all state updates on posedge.
- rst_n  in  1  synchronous active-low reset.
- opcode  in  4  IR[15:12].
- bit5  in  1  IR[5]; 1 selects the immediate form of ADD/AND.
- branch_enable  in  1  datapath BR condition (IR nzp AND CC), valid in BR state.
- mem_resp  in  1  memory completion; may be high in the same cycle a request is raised.
- load_pc, load_ir, load_regfile, load_mar, load_mdr, load_cc  out  1 each  register load enables.
- pcmux_sel  out  2  0=PC+2, 1=PC+offset9 adder, 2=SR1.
- alumux_sel  out  2  0=SR2, 1=imm5, 2=offset6.
- aluop  out  2  0=ADD, 1=AND, 2=NOT, 3=PASS_B.
- regfilemux_sel  out  2  0=ALU, 1=MDR, 2=PC+offset9 adder.
- marmux_sel  out  1  0=ALU, 1=PC.
- mdrmux_sel  out  1  0=ALU, 1=mem_rdata.
- storemux_sel  out  1  1=read IR[11:9] as SR1 (STR source).
- mem_read, mem_write  out  1 each  memory request, held until mem_resp.
- instr_done  out  1  one-cycle pulse in the final cycle of each instruction.
- instret  out  CNT_W  count of instr_done pulses.

Behaviour:
- Moore FSM. All outputs are decoded from the current state only, except the mem_resp-qualified loads in memory states. Any output not listed for a state is 0.
- Reset: rst_n=0 at a posedge sets state=FETCH1 and instret=0. Reset wins over every transition, including mid memory wait; mem_read/mem_write fall on the cycle after the reset edge.
- FETCH1: marmux_sel=1, load_mar, pcmux_sel=0, load_pc. Next state FETCH2.
- FETCH2: mem_read, mdrmux_sel=1. load_mdr=mem_resp. Stay while mem_resp=0; on mem_resp=1 go to FETCH3.
- FETCH3: load_ir. Next state DECODE.
- DECODE: no outputs. Next state by opcode:
  - 0001 → ADD
  - 0101 → AND
  - 1001 → NOT
  - 0000 → BR
  - 0110 → LDR1
  - 0111 → STR1
  - 1100 → JMP
  - 1110 → LEA
  - any other opcode → ILLEGAL
- ADD / AND: aluop=0 or 1 respectively, alumux_sel={0,bit5}, load_regfile, load_cc, instr_done. Next FETCH1.
- NOT: aluop=2, load_regfile, load_cc, instr_done. Next FETCH1.
- BR: instr_done if branch_enable=0, then next FETCH1; else next BR_TAKEN.
- BR_TAKEN: pcmux_sel=1, load_pc, instr_done. Next FETCH1.
- LDR1: alumux_sel=2, aluop=0, marmux_sel=0, load_mar. Next LDR2.
- LDR2: mem_read, mdrmux_sel=1, load_mdr=mem_resp. Wait as in FETCH2; then LDR3.
- LDR3: regfilemux_sel=1, load_regfile, load_cc, instr_done. Next FETCH1.
- STR1: alumux_sel=2, aluop=0, load_mar. Next STR2.
- STR2: storemux_sel=1, aluop=3, alumux_sel=0, mdrmux_sel=0, load_mdr. Next STR3.
  - STR2 routes SR1 through the ALU as B; the datapath maps storemux so that SR1 appears on the SR2 read port.
- STR3: mem_write held until mem_resp; instr_done in the mem_resp cycle. Then FETCH1.
- JMP: pcmux_sel=2, load_pc, instr_done. Next FETCH1.
- LEA: regfilemux_sel=2, load_regfile, load_cc, instr_done. Next FETCH1.
- ILLEGAL: instr_done only (treated as a NOP). Next FETCH1.
- instret increments on every clock where instr_done=1 and rst_n=1; it wraps from all-ones to 0.
- Latency with zero-wait memory (mem_resp high on first request cycle):
  - ALU/JMP/LEA/ILLEGAL/BR not-taken: 5 cycles.
  - BR taken: 6 cycles.
  - LDR: 7 cycles.
  - STR: 7 cycles.
  - Each wait cycle adds 1.
- mem_read and mem_write are never asserted together.
- No request is issued outside FETCH2, LDR2 and STR3.

Test Plan:
- Reset then ADD reg (opcode 0001, bit5=0), mem_resp tied 1 → states FETCH1, FETCH2, FETCH3, DECODE, ADD. In the ADD cycle: alumux_sel=0, aluop=0, load_regfile=load_cc=1, instr_done=1. instret=1 afterwards.
- AND imm (0101, bit5=1), mem_resp delayed 3 cycles in FETCH2 → mem_read high 3 cycles with load_mdr=0, then 1 cycle with load_mdr=1. Total 8 cycles. alumux_sel=1, aluop=1.
- BR with branch_enable=0 then 1 → 5-cycle completion with load_pc=0 in BR; then 6-cycle completion with pcmux_sel=1 and load_pc=1 in BR_TAKEN.
- LDR then STR, mem_resp 1-cycle wait each → LDR3 has regfilemux_sel=1 and load_cc=1. STR3 holds mem_write 2 cycles, and mem_read stays 0 throughout STR.
- rst_n=0 during LDR2 wait → next cycle state=FETCH1, mem_read=0, instret=0. Opcode 1111 → ILLEGAL, 5 cycles, no load except fetch loads.
- CNT_W=4: run 17 NOPs → instret=1 (wrap verified).
